// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types and defaults for the CPU core.
// Holds the divider-controller state encoding and the default number of
// quiet cycles the divider gets between launches.
package mycpu_pkg;

    // Divider sequencer states, shared so EX-stage debug logic can decode them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } div_state_e;

    // Idle cycles with div_start low before the divider may be relaunched.
    localparam int DIV_DRAIN_CYCLES = 2;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the multicycle divider that sits beside it.
// Latches the operands, holds div_start while the divider works, parks the
// {remainder, quotient} result until EX advances, writes HI/LO exactly once,
// then keeps the divider quiet for DRAIN_CYCLES cycles before the next launch.
// A flush while the divider runs annuls it; a flush while parked drops the write.
// Optional feature: define DIV_FASTPATH_EN to skip the divider when either
// operand is zero (result 0/0 goes straight to HOLD).
// DRAIN_CYCLES must be at least 1.
module div_ctrl
    import mycpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = DIV_DRAIN_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_src_a,
    input  logic [31:0] ex_src_b,
    input  logic        ex_advance,
    input  logic        flush,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             sign_q, sign_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             fast_zero;

`ifdef DIV_FASTPATH_EN
    // A zero operand has a known 0/0 answer; no need to occupy the divider.
    assign fast_zero = (ex_src_a == 32'd0) || (ex_src_b == 32'd0);
`else
    assign fast_zero = 1'b0;
`endif

    assign div_sign = sign_q;
    assign div_a    = a_q;
    assign div_b    = b_q;
    assign hi_wdata = hi_q;
    assign lo_wdata = lo_q;

    // Next-state and divider/pipeline handshake decode.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        sign_d      = sign_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        div_start   = 1'b0;
        div_annul   = 1'b0;
        stall_req   = 1'b0;
        hilo_we     = 1'b0;

        case (state_q)
            IDLE: begin
                // A flushed DIV never launches and must not freeze the front end.
                if (ex_div_valid && !flush) begin
                    stall_req = 1'b1;
                    sign_d    = ex_div_signed;
                    a_d       = ex_src_a;
                    b_d       = ex_src_b;
                    if (fast_zero) begin
                        hi_d    = 32'd0;
                        lo_d    = 32'd0;
                        state_d = HOLD;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (flush) begin
                    div_annul   = 1'b1;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    div_start = 1'b1;
                    if (div_ready) begin
                        hi_d    = div_result[63:32];
                        lo_d    = div_result[31:0];
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Flush outranks ex_advance: the instruction dies without writing.
                if (flush || ex_advance) begin
                    hilo_we     = !flush;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // A DIV waiting behind us stays frozen until IDLE launches it.
                stall_req = ex_div_valid;
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            sign_q      <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            sign_q      <= sign_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider.
// Expected HI/LO come from plain arithmetic on the operands the bench chose;
// timing expectations come from transaction-level rules (launch wait after
// drain, stall dropping the cycle after div_ready, one HI/LO write per DIV).
module tb_div_ctrl;

    localparam int DRAIN   = 2;   // default quiet cycles between launches
    localparam int DIV_LAT = 12;  // behavioural divider latency in cycles
`ifdef DIV_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    typedef enum int {M_NORMAL, M_FLUSH_BUSY, M_FLUSH_READY, M_FLUSH_HOLD} mode_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid, ex_div_signed, ex_advance, flush;
    logic [31:0] ex_src_a, ex_src_b;
    logic        div_start, div_annul, div_sign;
    logic [31:0] div_a, div_b;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stall_req, hilo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int checks   = 0;
    int failures = 0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_valid (ex_div_valid),
        .ex_div_signed(ex_div_signed),
        .ex_src_a     (ex_src_a),
        .ex_src_b     (ex_src_b),
        .ex_advance   (ex_advance),
        .flush        (flush),
        .div_start    (div_start),
        .div_annul    (div_annul),
        .div_sign     (div_sign),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_result   (div_result),
        .div_ready    (div_ready),
        .stall_req    (stall_req),
        .hilo_we      (hilo_we),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata)
    );

    always #5 clk = ~clk;

    // {remainder, quotient} as the MIPS divider returns it; x/0 yields 0/0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: counts while div_start is held, pulses div_ready once.
    int div_cnt;
    always @(posedge clk) begin
        if (rst || !div_start) begin
            div_cnt   <= 0;
            div_ready <= 1'b0;
        end else if (div_ready) begin
            div_ready <= 1'b0;
        end else if (div_cnt == DIV_LAT - 1) begin
            div_ready  <= 1'b1;
            div_result <= ref_div(div_sign, div_a, div_b);
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_start"}, div_start, 0);
        check({pfx, "_annul"}, div_annul, 0);
        check({pfx, "_sign"},  div_sign,  0);
        check({pfx, "_a"},     div_a,     0);
        check({pfx, "_b"},     div_b,     0);
        check({pfx, "_we"},    hilo_we,   0);
        check({pfx, "_hi"},    hi_wdata,  0);
        check({pfx, "_lo"},    lo_wdata,  0);
        check({pfx, "_stall"}, stall_req, 0);
    endtask

    // n cycles with no DIV in EX: everything towards divider and pipeline quiet.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            check("gap_quiet", {stall_req, div_start, hilo_we, div_annul}, 0);
            tick();
        end
    endtask

    // One DIV/DIVU from presentation in EX to the cycle after it leaves.
    // pre_exp: cycles the DIV must wait frozen before div_start (1 from IDLE).
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int pre_exp, input int hold_extra,
                           input mode_e mode, input int flush_at);
        logic [63:0] exp_r;
        bit fast, flushed, prev_ready, start_gap, op_moved, we_seen, annul_seen;
        int pre_n, busy_n, guard;
        exp_r      = ref_div(sgn, a, b);
        fast       = FASTPATH && (a == 32'd0 || b == 32'd0);
        flushed    = 0;
        prev_ready = 0;
        start_gap  = 0;
        op_moved   = 0;
        we_seen    = 0;
        annul_seen = 0;
        pre_n      = 0;
        busy_n     = 0;

        ex_div_valid  = 1'b1;
        ex_div_signed = sgn;
        ex_src_a      = a;
        ex_src_b      = b;
        ex_advance    = 1'b0;
        flush         = 1'b0;
        settle();

        // Frozen, divider not yet started (drain remainder plus launch cycle).
        guard = 0;
        while (stall_req && !div_start && guard < 50) begin
            pre_n++;
            we_seen    |= hilo_we;
            annul_seen |= div_annul;
            tick();
            guard++;
        end
        check("launch_wait", pre_n, pre_exp);

        if (fast) begin
            check("fast_no_start", div_start, 0);
            check("fast_stall_drop", stall_req, 0);
        end else begin
            check("latched_a", div_a, a);
            check("latched_b", div_b, b);
            check("latched_sign", div_sign, sgn);
            // EX operands change under us; the divider must keep the latched ones.
            ex_src_a = $urandom;
            ex_src_b = $urandom;
            settle();
            guard = 0;
            while (stall_req && !flushed && guard < 100) begin
                if (!div_start) start_gap = 1;
                if (div_a !== a || div_b !== b || div_sign !== sgn) op_moved = 1;
                we_seen    |= hilo_we;
                annul_seen |= div_annul;
                if ((mode == M_FLUSH_BUSY && busy_n == flush_at) ||
                    (mode == M_FLUSH_READY && div_ready)) begin
                    flush = 1'b1;
                    settle();
                    check("flush_annul", div_annul, 1);
                    check("flush_start_low", div_start, 0);
                    check("flush_no_we", hilo_we, 0);
                    tick();
                    flush        = 1'b0;
                    ex_div_valid = 1'b0;
                    settle();
                    check("annul_one_cycle", div_annul, 0);
                    check("flush_no_restart", {div_start, hilo_we, stall_req}, 0);
                    flushed = 1;
                end else begin
                    prev_ready = div_ready;
                    busy_n++;
                    tick();
                    guard++;
                end
            end
            check("busy_bounded", guard < 100, 1);
            if (!flushed) begin
                check("stall_until_ready_plus1", prev_ready, 1);
                check("start_held", start_gap, 0);
                check("operands_held", op_moved, 0);
            end
        end
        check("no_early_we", we_seen, 0);
        check("no_stray_annul", annul_seen, 0);
        if (flushed) return;

        // Parked result: nothing written until EX advances.
        for (int i = 0; i < hold_extra; i++) begin
            check("hold_wait", {hilo_we, stall_req, div_start, div_annul}, 0);
            tick();
        end
        ex_advance = 1'b1;
        flush      = (mode == M_FLUSH_HOLD);
        settle();
        if (mode == M_FLUSH_HOLD) begin
            check("hold_flush_no_we", hilo_we, 0);
        end else begin
            check("hilo_we", hilo_we, 1);
            check("hi_wdata", hi_wdata, exp_r[63:32]);
            check("lo_wdata", lo_wdata, exp_r[31:0]);
        end
        check("hold_annul_low", div_annul, 0);
        tick();
        ex_advance   = 1'b0;
        flush        = 1'b0;
        ex_div_valid = 1'b0;
        settle();
        check("single_write", hilo_we, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, pre, sel;
        logic sg;
        logic [31:0] ra, rb;

        rst = 1'b1;
        ex_div_valid = 1'b0; ex_div_signed = 1'b0; ex_advance = 1'b0; flush = 1'b0;
        ex_src_a = 32'd0; ex_src_b = 32'd0;
        tick();
        tick();
        check_outputs_zero("in_reset");
        rst = 1'b0;
        settle();
        check_outputs_zero("after_reset");

        // DIVU 100/7 and DIV -7/2.
        run_div(1'b0, 32'd100, 32'd7, 1, 0, M_NORMAL, 0);
        gap(DRAIN);
        run_div(1'b1, -32'sd7, 32'd2, 1, 1, M_NORMAL, 0);

        // Chained straight behind: flushed DIV 10 cycles into BUSY, then 8/2, 9/3.
        run_div(1'b1, 32'd1234, 32'd5, DRAIN + 1, 0, M_FLUSH_BUSY, 10);
        run_div(1'b0, 32'd8, 32'd2, DRAIN + 1, 3, M_NORMAL, 0);
        run_div(1'b0, 32'd9, 32'd3, DRAIN + 1, 0, M_NORMAL, 0);

        // Flush coinciding with div_ready, then divide-by-zero.
        gap(1);
        run_div(1'b1, 32'd50, -32'sd3, DRAIN, 0, M_FLUSH_READY, 0);
        run_div(1'b1, 32'd5, 32'd0, DRAIN + 1, 1, M_NORMAL, 0);

        // Flush together with ex_advance in HOLD.
        gap(DRAIN);
        run_div(1'b0, 32'd77, 32'd5, 1, 1, M_FLUSH_HOLD, 0);

        // Flush in IDLE: no launch, controller stays IDLE.
        gap(DRAIN);
        ex_div_valid = 1'b1; ex_src_a = 32'd40; ex_src_b = 32'd4; flush = 1'b1;
        settle();
        check("idle_flush_start", div_start, 0);
        tick();
        flush = 1'b0; ex_div_valid = 1'b0;
        settle();
        check("idle_flush_no_launch", {div_start, stall_req}, 0);
        run_div(1'b0, 32'd91, 32'd4, 1, 0, M_NORMAL, 0);

        // Reset in the middle of a division.
        gap(DRAIN);
        ex_div_valid = 1'b1; ex_div_signed = 1'b1; ex_src_a = -32'sd1000; ex_src_b = 32'd3;
        settle();
        for (int i = 0; i < 6; i++) tick();
        check("pre_reset_busy", div_start, 1);
        rst = 1'b1;
        ex_div_valid = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        check_outputs_zero("mid_reset");
        gap(3);
        run_div(1'b0, 32'd6, 32'd3, 1, 0, M_NORMAL, 0);
        gap(DRAIN);
        run_div(1'b0, 32'd0, 32'd9, 1, 0, M_NORMAL, 0);

        // Randomised traffic with random spacing, hold time and flushes.
        for (int n = 0; n < 25; n++) begin
            k   = $urandom_range(0, 3);
            gap(k);
            pre = (k >= DRAIN) ? 1 : DRAIN + 1 - k;
            sg  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) ra = 32'd0;
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sg && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            sel = $urandom_range(0, 7);
            if (sel == 0)
                run_div(sg, ra, rb, pre, $urandom_range(0, 2), M_FLUSH_BUSY,
                        $urandom_range(0, DIV_LAT));
            else if (sel == 1)
                run_div(sg, ra, rb, pre, $urandom_range(0, 2), M_FLUSH_HOLD, 0);
            else
                run_div(sg, ra, rb, pre, $urandom_range(0, 2), M_NORMAL, 0);
        end
        gap(DRAIN + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter: DRAIN_CYCLES, 2, idle cycles with div_start low before the next divider launch.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: ex_div_valid  input  1  EX holds a DIV/DIVU; ex_div_signed  input  1  1=DIV, 0=DIVU.
REQ-005 SHALL have ports: ex_src_a  input  32  dividend; ex_src_b  input  32  divisor.
REQ-006 SHALL have ports: ex_advance  input  1  EX instruction moves to MEM this cycle; flush  input  1  exception or branch flush of EX.
REQ-007 SHALL have ports: div_start  output  1; div_annul  output  1; div_sign  output  1; div_a  output  32; div_b  output  32 (all to divider).
REQ-008 SHALL have ports: div_result  input  64  {remainder, quotient}; div_ready  input  1  divider result valid.
REQ-009 SHALL have ports: stall_req  output  1  freeze IF..EX; hilo_we  output  1; hi_wdata  output  32; lo_wdata  output  32.

Function
REQ-010 SHALL implement states IDLE, BUSY, HOLD, DRAIN.
REQ-011 IDLE: ex_div_valid and no flush -> latch ex_div_signed/ex_src_a/ex_src_b into div_sign/div_a/div_b, go BUSY; stall_req asserted same cycle (combinational on ex_div_valid in IDLE).
REQ-012 BUSY: div_start=1, operands held constant, stall_req=1.
REQ-013 BUSY and div_ready: capture hi=div_result[63:32], lo=div_result[31:0]; go HOLD; div_start drops next cycle.
REQ-014 HOLD: div_start=0, stall_req=0, hilo_we=1, hi_wdata/lo_wdata from captured values; stays until ex_advance, then DRAIN.
REQ-015 hilo_we SHALL be asserted only in HOLD, so HI/LO is written exactly once, in the cycle ex_advance=1.
REQ-016 DRAIN: div_start=0 for DRAIN_CYCLES cycles (counter), then IDLE; ex_div_valid during DRAIN SHALL keep stall_req=1 and be launched on IDLE entry.
REQ-017 flush in BUSY: div_annul=1 and div_start=0 that cycle; go DRAIN; no HI/LO write.
REQ-018 flush in HOLD: hilo_we=0 that cycle; go DRAIN.
REQ-019 flush in IDLE with ex_div_valid: no launch, stay IDLE.
REQ-020 flush has priority over div_ready and ex_advance in the same cycle.
REQ-021 div_annul SHALL be 0 in all other cases.

Reset
REQ-022 rst SHALL force IDLE, drain counter 0, div_start=0, div_annul=0, div_sign=0, div_a=0, div_b=0, hilo_we=0, hi_wdata=0, lo_wdata=0, stall_req=0; reset mid-operation abandons the division with no HI/LO write.

Configuration
REQ-023 DIV_FASTPATH_EN defined: in IDLE, ex_src_b==0 or ex_src_a==0 SHALL skip the divider, load hi=lo=0, go directly to HOLD next cycle (stall_req=1 for that one cycle only).
REQ-024 DIV_FASTPATH_EN undefined: all divisions go through BUSY; zero operands return divider output (0,0).

Structure
REQ-025 State enum (IDLE/BUSY/HOLD/DRAIN) and DRAIN_CYCLES default SHALL live in shared package mycpu_pkg.
REQ-026 No sub-module; div is instantiated beside div_ctrl in the EX stage, not inside it.

Verification
REQ-027 DIVU 100/7, ex_advance=1 on HOLD -> hilo_we one cycle, hi=2, lo=14.
REQ-028 DIV -7/2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD; stall_req high from launch until div_ready+1.
REQ-029 flush 10 cycles into BUSY -> div_annul pulse one cycle, no hilo_we, DRAIN 2 cycles, IDLE.
REQ-030 Back-to-back DIVU 8/2 then 9/3 with HOLD held 3 cycles by ex_advance=0 -> hilo_we only in advancing cycle; second launch after 2 DRAIN cycles; lo=4 then 3.
REQ-031 DIV 5/0 with DIV_FASTPATH_EN -> HOLD after 1 cycle, hi=lo=0, div_start never asserted; without macro -> BUSY, hi=lo=0.
REQ-032 rst asserted in BUSY -> all outputs 0 next cycle; new DIVU 6/3 after release yields lo=2, hi=0.
